legv8_control_unit: RTL
=======================

// Module: legv8_control_unit
// PURPOSE
//  Multicycle FSM that sequences the LEGv8 datapath. Consumes the IR and status
//  outputs, and drives the 34-bit ControlWord plus the 64-bit constant that the
//  DE0 test wrapper currently takes from DIP switches. Sits beside the datapath
//  in the CPU top level. Adds memory wait handshake, halt and illegal-opcode trap.
// PARAMETERS
//  CW_W    34  control word width (field map in legv8_pkg)
//  K_W     64  constant width
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  instruction   in   32  IR output of datapath
//  status        in   5   {V,C,N,Z,Z_nr}; V..Z registered flags, Z_nr live ALU zero
//  mem_ready     in   1   memory has completed current access (RAM only)
//  control_word  out  34  [4:0]DA [9:5]SA [14:10]SB [19:15]FS [20]regW [21]ramW [22]EN_MEM
//                         [23]EN_ALU [24]EN_B [25]EN_PC [26]Bsel [27]PCsel [29:28]PS [30]IL [31]SL [33:32]size
//  constant      out  64  immediate/offset for datapath
//  state_out     out  3   FSM state, for GPIO display
//  halted        out  1   high in S_HALT
//  illegal       out  1   sticky; set when S_HALT entered via undecoded opcode
// BEHAVIOUR
//  - Reset asserted (any time, including mid-access): state=S_RESET. control_word=0
//    (regW/ramW/EN_*=0, PS=00 hold = NOP). constant=0, halted=0, illegal=0.
//  - S_RESET -> S_FETCH on first edge after reset deasserts.
//  - S_FETCH: EN_PC=1 (address=PC), IL=1, PS=01 (PC+=4), size=11.
//    Stay while mem_ready=0 with IL/PS forced 0. Leave when mem_ready=1 -> S_EXEC.
//  - S_EXEC (decode is combinational on instruction):
//    R-type  ADD/SUB/AND/ORR/EOR/ADDS/SUBS
//      DA=Rd, SA=Rn, SB=Rm, Bsel=0, EN_ALU=1, regW=1, SL=1 only for ADDS/SUBS.
//      -> S_FETCH.
//    ADDI/SUBI
//      K=zext(imm12[21:10]), Bsel=1, else as R-type. -> S_FETCH.
//    MOVZ
//      K=imm16[20:5]<<(16*hw[22:21]), FS=PASS_B, Bsel=1, regW=1. -> S_FETCH.
//    LDUR/STUR
//      K=sext(imm9[20:12]), SA=Rn, FS=ADD, Bsel=1, address from ALU, size=11.
//      LDUR: EN_MEM=1, regW=1, DA=Rt.
//      STUR: SB=Rt, EN_B=1, ramW=1.
//      If mem_ready=0 -> S_MEMWAIT holding identical word; else -> S_FETCH.
//    B
//      K=sext(imm26), PS=11 (PC+=4*K, relative to PC+4 minus 4). -> S_FETCH.
//    CBZ/CBNZ
//      SB=Rt, FS=PASS_B. PS=11 if Z_nr==1 (CBZ) / Z_nr==0 (CBNZ), else PS=00.
//      K=sext(imm19[23:5]). -> S_FETCH.
//    B.cond
//      cond=[3:0] evaluated on registered {V,C,N,Z} per ARM table (EQ..LE, AL).
//      Taken -> PS=11 else 00. K as CB. -> S_FETCH.
//    instruction==32'h0 -> S_HALT. Any other opcode -> S_HALT with illegal=1.
//  - S_MEMWAIT: repeat EXEC word until mem_ready=1; regW/ramW asserted only in the
//    mem_ready=1 cycle. -> S_FETCH.
//  - S_HALT: control_word=0, halted=1, terminal until reset.
//  - Latency: 2 cycles/instr with zero-wait memory; +1 per wait cycle.
//  - Branch arithmetic: constant is a word offset; datapath applies <<2.
//    Sign extension is to the full 64 bits.
//  - control_word/constant are Moore outputs of (state, instruction, status); no
//    registered output stage. Z_nr usage is intentionally same-cycle.
// STRUCTURE
//  legv8_pkg:
//    - state enum (S_RESET,S_FETCH,S_EXEC,S_MEMWAIT,S_HALT = 0..4)
//    - control word field offsets
//    - FS codes AND=00000 ORR=00100 ADD=01000 SUB=01001 EOR=01100 PASS_B=10100
//    - 11-bit opcode constants
//    - PS codes HOLD=00 INC=01 REL=11
//  Sub-module legv8_cond_eval: (cond[3:0], V,C,N,Z) -> taken.
// TESTING
//  1. Reset low mid-S_MEMWAIT
//       -> next sample control_word=0, state_out=0.
//     Release
//       -> S_FETCH with IL=1, PS=01.
//  2. IR=ADDI X1,X2,#5 (0x91001441), mem_ready=1
//       -> EXEC: DA=1, SA=2, Bsel=1, FS=01000, regW=1, constant=5, then S_FETCH.
//  3. IR=LDUR X3,[X4,#-8] (0xF85F8083), mem_ready low 3 cycles
//       -> constant=64'hFFFF_FFFF_FFFF_FFF8.
//       -> 3 S_MEMWAIT cycles, regW=0 in each; regW=1 only in the ready cycle.
//  4. IR=B.EQ #-2 with status Z=1
//       -> PS=11, constant=-2.
//     Same with Z=0
//       -> PS=00.
//     CBZ X5 with Z_nr=1/0
//       -> PS=11/00.
//  5. IR=0x00000000
//       -> S_HALT, halted=1, illegal=0, word stays 0 for 10 cycles.
//     IR=0xFFFFFFFF
//       -> halted=1, illegal=1.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared states, control word layout, ALU/PC codes and opcodes for the LEGv8 control unit
package legv8_pkg;
  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_HALT    = 3'd4
  } state_t;
  typedef struct packed {
    logic [1:0] size;
    logic       sl;
    logic       il;
    logic [1:0] ps;
    logic       pcsel;
    logic       bsel;
    logic       en_pc;
    logic       en_b;
    logic       en_alu;
    logic       en_mem;
    logic       ramw;
    logic       regw;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } cw_t;
  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_ORR    = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01001;
  localparam logic [4:0] FS_EOR    = 5'b01100;
  localparam logic [4:0] FS_PASS_B = 5'b10100;
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b11;
  localparam logic [1:0] SIZE_DW = 2'b11;
  localparam logic [10:0] OP_ADD   = 11'h458;
  localparam logic [10:0] OP_SUB   = 11'h658;
  localparam logic [10:0] OP_AND   = 11'h450;
  localparam logic [10:0] OP_ORR   = 11'h550;
  localparam logic [10:0] OP_EOR   = 11'h650;
  localparam logic [10:0] OP_ADDS  = 11'h558;
  localparam logic [10:0] OP_SUBS  = 11'h758;
  localparam logic [10:0] OP_ADDI  = 11'h488;
  localparam logic [10:0] OP_SUBI  = 11'h688;
  localparam logic [10:0] OP_MOVZ  = 11'h694;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [10:0] OP_B     = 11'h0A0;
  localparam logic [10:0] OP_CBZ   = 11'h5A0;
  localparam logic [10:0] OP_CBNZ  = 11'h5A8;
  localparam logic [10:0] OP_BCOND = 11'h2A0;
endpackage

// File: rtl/legv8_cond_eval.sv
// legv8_cond_eval: ARM condition-code evaluation on registered flags
module legv8_cond_eval (
  input  logic [3:0] cond,
  input  logic       v,
  input  logic       c,
  input  logic       n,
  input  logic       z,
  output logic       taken
);
  logic base;
  // even codes give the base test; odd codes invert it, except AL/NV which are always taken
  always_comb begin
    base = cond[3:1] == 3'd0 ? z :
           cond[3:1] == 3'd1 ? c :
           cond[3:1] == 3'd2 ? n :
           cond[3:1] == 3'd3 ? v :
           cond[3:1] == 3'd4 ? (c && !z) :
           cond[3:1] == 3'd5 ? (n == v) :
           cond[3:1] == 3'd6 ? (!z && (n == v)) : 1'b1;
    taken = cond[3:1] == 3'd7 ? 1'b1 : base ^ cond[0];
  end
endmodule

// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multicycle FSM sequencing the LEGv8 datapath with memory wait, halt and illegal trap
module legv8_control_unit
  import legv8_pkg::*;
#(
  parameter int CW_W = 34,
  parameter int K_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [4:0]      status,
  input  logic            mem_ready,
  output logic [CW_W-1:0] control_word,
  output logic [K_W-1:0]  constant,
  output logic [2:0]      state_out,
  output logic            halted,
  output logic            illegal
);
  state_t state_q, state_d;
  logic illegal_q, illegal_d;
  cw_t cw, ex;
  logic [63:0] k, ex_k;
  logic [10:0] op;
  logic [4:0] rd, rn, rm, alu_fs;
  logic is_r, is_imm, is_subi, is_flags, is_movz, is_ld, is_st, is_b, is_cbz, is_cbnz, is_bcond;
  logic is_mem, is_halt, known, cond_taken;
  assign op       = instruction[31:21];
  assign rd       = instruction[4:0];
  assign rn       = instruction[9:5];
  assign rm       = instruction[20:16];
  assign is_r     = op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS};
  assign is_subi  = op[10:1] == OP_SUBI[10:1];
  assign is_imm   = op[10:1] == OP_ADDI[10:1] || is_subi;
  assign is_flags = op == OP_ADDS || op == OP_SUBS;
  assign is_movz  = op[10:2] == OP_MOVZ[10:2];
  assign is_ld    = op == OP_LDUR;
  assign is_st    = op == OP_STUR;
  assign is_b     = op[10:5] == OP_B[10:5];
  assign is_cbz   = op[10:3] == OP_CBZ[10:3];
  assign is_cbnz  = op[10:3] == OP_CBNZ[10:3];
  assign is_bcond = op[10:3] == OP_BCOND[10:3];
  assign is_mem   = is_ld || is_st;
  assign is_halt  = instruction == 32'h0;
  assign known    = is_r || is_imm || is_movz || is_mem || is_b || is_cbz || is_cbnz || is_bcond;
  assign alu_fs   = (op == OP_SUB || op == OP_SUBS || is_subi) ? FS_SUB :
                    op == OP_AND ? FS_AND :
                    op == OP_ORR ? FS_ORR :
                    op == OP_EOR ? FS_EOR : FS_ADD;
  legv8_cond_eval u_cond (
    .cond (instruction[3:0]),
    .v    (status[4]),
    .c    (status[3]),
    .n    (status[2]),
    .z    (status[1]),
    .taken(cond_taken)
  );
  // execute-phase word and constant; register/memory writes wait for the memory to complete
  always_comb begin
    ex = '0;
    ex_k = '0;
    if (is_r || is_imm) begin
      ex.da = rd;
      ex.sa = rn;
      ex.sb = rm;
      ex.fs = alu_fs;
      ex.bsel = is_imm;
      ex.en_alu = 1'b1;
      ex.regw = 1'b1;
      ex.sl = is_flags;
      ex_k = is_imm ? {52'd0, instruction[21:10]} : 64'd0;
    end else if (is_movz) begin
      ex.da = rd;
      ex.fs = FS_PASS_B;
      ex.bsel = 1'b1;
      ex.en_alu = 1'b1;
      ex.regw = 1'b1;
      ex_k = {48'd0, instruction[20:5]} << {instruction[22:21], 4'd0};
    end else if (is_mem) begin
      ex.da = is_ld ? rd : 5'd0;
      ex.sa = rn;
      ex.sb = is_st ? rd : 5'd0;
      ex.fs = FS_ADD;
      ex.bsel = 1'b1;
      ex.size = SIZE_DW;
      ex.en_mem = is_ld;
      ex.en_b = is_st;
      ex.regw = is_ld && mem_ready;
      ex.ramw = is_st && mem_ready;
      ex_k = {{55{instruction[20]}}, instruction[20:12]};
    end else if (is_b) begin
      ex.ps = PS_REL;
      ex_k = {{38{instruction[25]}}, instruction[25:0]};
    end else if (is_cbz || is_cbnz) begin
      ex.sb = rd;
      ex.fs = FS_PASS_B;
      ex.ps = (status[0] == is_cbz) ? PS_REL : PS_HOLD;
      ex_k = {{45{instruction[23]}}, instruction[23:5]};
    end else if (is_bcond) begin
      ex.ps = cond_taken ? PS_REL : PS_HOLD;
      ex_k = {{45{instruction[23]}}, instruction[23:5]};
    end
  end
  // next state, sticky illegal flag and Moore outputs per state
  always_comb begin
    state_d = state_q;
    illegal_d = illegal_q;
    cw = '0;
    k = '0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        cw.en_pc = 1'b1;
        cw.size = SIZE_DW;
        cw.il = mem_ready;
        cw.ps = mem_ready ? PS_INC : PS_HOLD;
        state_d = mem_ready ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        cw = ex;
        k = ex_k;
        state_d = !known ? S_HALT : (is_mem && !mem_ready) ? S_MEMWAIT : S_FETCH;
        illegal_d = illegal_q || (!known && !is_halt);
      end
      S_MEMWAIT: begin
        cw = ex;
        k = ex_k;
        state_d = mem_ready ? S_FETCH : S_MEMWAIT;
      end
      default: state_d = S_HALT;
    endcase
  end
  // state and sticky illegal registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
  assign control_word = cw;
  assign constant     = k;
  assign state_out    = state_q;
  assign halted       = state_q == S_HALT;
  assign illegal      = illegal_q;
endmodule
